// File: rtl/pcm_to_i2s_if.sv
// pcm_to_i2s_if: PCM sample-pair handshake bus between a producer and the I2S transmitter.
// The producer drives the master side and the transmitter uses the slave side.
interface pcm_to_i2s_if #(
    parameter int unsigned DATA_BITS = 12
);
    logic [DATA_BITS-1:0] in_left;
    logic [DATA_BITS-1:0] in_right;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_left,
        output in_right,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_left,
        input  in_right,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: serializes one stereo PCM pair per frame onto I2S (sck = clk/2, MSB first,
// ws leading the MSB by one bit clock). A one-deep holding register decouples the producer
// from frame timing; a frame that starts without a pending pair pulses underrun.
// Optional build macro: PCM_TX_HOLD_LAST_EN -- on underrun, repeat the last loaded pair
// instead of sending silence.
module pcm_to_i2s #(
    parameter int unsigned DATA_BITS = 12,
    parameter int unsigned SLOT_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    pcm_to_i2s_if.slave pcm,
    output logic        sck,
    output logic        ws,
    output logic        sd,
    output logic        underrun
);
    localparam int unsigned      POS_W    = $clog2(2 * SLOT_BITS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT_BITS - 1);
    localparam logic [POS_W-1:0] SLOT     = POS_W'(SLOT_BITS);
    localparam logic [POS_W-1:0] DBITS    = POS_W'(DATA_BITS);

    logic                 sck_q;
    logic                 ws_q;
    logic                 sd_q;
    logic                 underrun_q;
    logic                 hold_full_q;
    logic [POS_W-1:0]     pos_q;
    logic [DATA_BITS-1:0] hold_l_q;
    logic [DATA_BITS-1:0] hold_r_q;
    logic [DATA_BITS-1:0] tx_l_q;
    logic [DATA_BITS-1:0] tx_r_q;

    logic [POS_W-1:0]     pos_d;
    logic [POS_W-1:0]     slot_k;
    logic [DATA_BITS-1:0] word;
    logic [DATA_BITS-1:0] mask;
    logic [DATA_BITS-1:0] fill_l;
    logic [DATA_BITS-1:0] fill_r;
    logic                 fall;
    logic                 boundary;
    logic                 transfer;
    logic                 ws_d;
    logic                 sd_d;

`ifdef PCM_TX_HOLD_LAST_EN
    logic [DATA_BITS-1:0] last_l_q;
    logic [DATA_BITS-1:0] last_r_q;

    // Remember the most recent pair that was actually loaded at a frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            last_l_q <= '0;
            last_r_q <= '0;
        end else if (boundary && hold_full_q) begin
            last_l_q <= hold_l_q;
            last_r_q <= hold_r_q;
        end
    end

    assign fill_l = last_l_q;
    assign fill_r = last_r_q;
`else
    assign fill_l = '0;
    assign fill_r = '0;
`endif

    // Next bit position, word select and serial bit for the coming falling event
    always_comb begin
        fall     = sck_q;
        boundary = sck_q && (pos_q == POS_LAST);
        transfer = pcm.in_valid && !hold_full_q;
        pos_d    = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        ws_d     = (pos_d >= SLOT);
        slot_k   = ws_d ? (pos_d - SLOT) : pos_d;
        word     = ws_d ? tx_r_q : tx_l_q;
        mask     = '0;
        sd_d     = 1'b0;
        if ((slot_k != '0) && (slot_k <= DBITS)) begin
            mask = {{(DATA_BITS-1){1'b0}}, 1'b1} << (DBITS - slot_k);
            sd_d = |(word & mask);
        end
    end

    // Bit clock, serializer state, holding register and frame-boundary load
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q       <= 1'b0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            pos_q       <= '0;
            underrun_q  <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            tx_l_q      <= '0;
            tx_r_q      <= '0;
        end else begin
            sck_q      <= !sck_q;
            underrun_q <= 1'b0;
            // A transfer only happens while the holding register is empty, so it never
            // collides with the boundary load below; a same-cycle transfer is kept for
            // the next frame while this boundary takes the underrun path.
            if (transfer) begin
                hold_l_q    <= pcm.in_left;
                hold_r_q    <= pcm.in_right;
                hold_full_q <= 1'b1;
            end
            if (fall) begin
                pos_q <= pos_d;
                ws_q  <= ws_d;
                sd_q  <= sd_d;
                if (boundary) begin
                    if (hold_full_q) begin
                        tx_l_q      <= hold_l_q;
                        tx_r_q      <= hold_r_q;
                        hold_full_q <= 1'b0;
                    end else begin
                        tx_l_q     <= fill_l;
                        tx_r_q     <= fill_r;
                        underrun_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign pcm.in_ready = !hold_full_q;
    assign sck          = sck_q;
    assign ws           = ws_q;
    assign sd           = sd_q;
    assign underrun     = underrun_q;
endmodule
